// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//
// Shares the single FIFO write port among NREQ producers. The arbitration is
// round-robin, and each grant is limited to a bounded burst. Every grant
// starts with one arbitration cycle in IDLE. In BURST the granted producer's
// words go straight through to the FIFO while the FIFO is not full.
//
// Parameters
//   NREQ       number of producers (2..8)
//   DW         data word width
//   MAX_BURST  max words taken from one grant holder before rotation (>=1)
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   req_valid   per-producer "word available"
//   req_data    producer i word at [i*DW +: DW]
//   req_ack     one-hot, word of producer i consumed this cycle
//   fifo_full   FIFO cannot accept a write this cycle
//   fifo_we     write strobe to the FIFO
//   fifo_wdata  write data to the FIFO (zero when not writing)
//   grant_id    current/last grant holder (registered)
//   busy        high while in BURST (registered)

module fifo_write_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4,
    localparam int GW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ack,
    input  logic               fifo_full,
    output logic               fifo_we,
    output logic [DW-1:0]      fifo_wdata,
    output logic [GW-1:0]      grant_id,
    output logic               busy
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [GW-1:0] LAST_ID = GW'(NREQ - 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;

    logic            grant_valid;
    logic            write_ok;
    logic [DW-1:0]   sel_data;
    logic [GW-1:0]   winner;

    // Round-robin pick. The scan starts just after the last holder and wraps
    // modulo NREQ. The loop runs from the farthest offset down to the
    // nearest, so the nearest valid index is the one that is kept.
    function automatic logic [GW-1:0] pick_next(
        input logic [GW-1:0]   last,
        input logic [NREQ-1:0] valid
    );
        logic [GW-1:0] result;
        int            idx;
        result = last;
        for (int k = NREQ; k >= 1; k--) begin
            idx = int'(last) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (valid[GW'(idx)]) result = GW'(idx);
        end
        return result;
    endfunction

    // Select the granted producer's word with a constant-index mux.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q == GW'(i)) sel_data = req_data[i*DW +: DW];
        end
    end

    // The write handshake is combinational. A full FIFO or a missing word
    // blocks the write in the same cycle, so no word is dropped.
    always_comb begin
        grant_valid = req_valid[grant_q];
        write_ok    = (state_q == BURST) && grant_valid && !fifo_full;
        winner      = pick_next(grant_q, req_valid);
        fifo_we     = write_ok;
        req_ack     = write_ok ? (NREQ'(1) << grant_q) : '0;
        fifo_wdata  = write_ok ? sel_data : '0;
    end

    // Next-state logic. A stall (full FIFO while the word is present) holds
    // the state, the grant and the count. Dropping valid releases the grant.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if ((|req_valid) && !fifo_full) begin
                    grant_d = winner;
                    cnt_d   = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (write_ok) begin
                    if (cnt_q + 1'b1 == MAX_CNT) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (!grant_valid) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == BURST);
    end

    // grant_id resets to the last index so that producer 0 has first priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= LAST_ID;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign grant_id = grant_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter
//
// Directed and random bench for fifo_write_arbiter with NREQ=4, DW=8 and
// MAX_BURST=4. Each producer i presents base[i] + seq[i]. seq[i] advances
// after every cycle in which the producer is acked, so a dropped or
// duplicated word shows up as a data mismatch.

module tb_fifo_write_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_ack;
    logic              fifo_full;
    logic              fifo_we;
    logic [DW-1:0]     fifo_wdata;
    logic [1:0]        grant_id;
    logic              busy;

    int                n_checks = 0;
    int                n_fail   = 0;
    int                seq [NREQ];
    logic [7:0]        base [NREQ];
    logic [NREQ-1:0]   ack_s;
    logic [15:0]       obs, exp_v;

    fifo_write_arbiter #(.NREQ(4), .DW(8), .MAX_BURST(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ack    (req_ack),
        .fifo_full  (fifo_full),
        .fifo_we    (fifo_we),
        .fifo_wdata (fifo_wdata),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Packed observation: {busy, grant_id, fifo_we, req_ack, fifo_wdata}
    function automatic logic [15:0] pack(input logic b, input logic [1:0] g,
                                         input logic w, input logic [3:0] a,
                                         input logic [7:0] d);
        return {b, g, w, a, d};
    endfunction

    task automatic drive_data();
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = base[i] + 8'(seq[i]);
    endtask

    // Capture the handshake, cross the edge, then advance the acked producers.
    task automatic tick();
        ack_s = req_ack;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) if (ack_s[i]) seq[i]++;
        drive_data();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            seq[i]  = 0;
            base[i] = 8'(i * 64);
        end
        drive_data();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 4'b1111;
        fifo_full = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            seq[i]  = 0;
            base[i] = 8'(i * 64);
        end
        drive_data();
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin
                rst       = 1'b0;
                req_valid = '0;
            end
            #2;
            obs = pack(busy, grant_id, fifo_we, req_ack, fifo_wdata);
            exp_v = pack(1'b0, 2'd3, 1'b0, 4'b0000, 8'h00);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("[TB] FAIL reset c%0d: got %h expected %h", c, obs, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_single_producer();
        do_reset();
        base[0] = 8'hA0;
        drive_data();
        for (int c = 0; c < 10; c++) begin
            req_valid = (seq[0] < 6) ? 4'b0001 : 4'b0000;
            #2;
            case (c)
                0:             exp_v = pack(1'b0, 2'd3, 1'b0, 4'b0000, 8'h00);
                1, 2, 3, 4:    exp_v = pack(1'b1, 2'd0, 1'b1, 4'b0001, 8'hA0 + 8'(c - 1));
                5:             exp_v = pack(1'b0, 2'd0, 1'b0, 4'b0000, 8'h00);
                6, 7:          exp_v = pack(1'b1, 2'd0, 1'b1, 4'b0001, 8'hA0 + 8'(c - 2));
                8:             exp_v = pack(1'b1, 2'd0, 1'b0, 4'b0000, 8'h00);
                default:       exp_v = pack(1'b0, 2'd0, 1'b0, 4'b0000, 8'h00);
            endcase
            obs = pack(busy, grant_id, fifo_we, req_ack, fifo_wdata);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("[TB] FAIL single c%0d: got %h expected %h", c, obs, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        int g, pg;
        do_reset();
        req_valid = 4'b1111;
        for (int b = 0; b < 5; b++) begin
            g  = b % 4;
            pg = (b == 0) ? 3 : (b - 1) % 4;
            #2;
            exp_v = pack(1'b0, 2'(pg), 1'b0, 4'b0000, 8'h00);
            obs = pack(busy, grant_id, fifo_we, req_ack, fifo_wdata);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("[TB] FAIL rr_bubble b%0d: got %h expected %h", b, obs, exp_v);
            end
            tick();
            for (int w = 0; w < 4; w++) begin
                #2;
                exp_v = pack(1'b1, 2'(g), 1'b1, 4'(1 << g), 8'(g * 64 + (b / 4) * 4 + w));
                obs = pack(busy, grant_id, fifo_we, req_ack, fifo_wdata);
                n_checks++;
                if (obs !== exp_v) begin
                    n_fail++;
                    $display("[TB] FAIL rr b%0d w%0d: got %h expected %h", b, w, obs, exp_v);
                end
                tick();
            end
        end
    endtask

    task automatic test_full_stall();
        do_reset();
        req_valid = 4'b0001;
        for (int c = 0; c < 9; c++) begin
            fifo_full = (c >= 3 && c <= 5);
            #2;
            case (c)
                0:          exp_v = pack(1'b0, 2'd3, 1'b0, 4'b0000, 8'h00);
                1, 2:       exp_v = pack(1'b1, 2'd0, 1'b1, 4'b0001, 8'(c - 1));
                3, 4, 5:    exp_v = pack(1'b1, 2'd0, 1'b0, 4'b0000, 8'h00);
                6, 7:       exp_v = pack(1'b1, 2'd0, 1'b1, 4'b0001, 8'(c - 4));
                default:    exp_v = pack(1'b0, 2'd0, 1'b0, 4'b0000, 8'h00);
            endcase
            obs = pack(busy, grant_id, fifo_we, req_ack, fifo_wdata);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("[TB] FAIL stall c%0d: got %h expected %h", c, obs, exp_v);
            end
            tick();
        end
        fifo_full = 1'b0;
    endtask

    task automatic test_release();
        do_reset();
        for (int c = 0; c < 7; c++) begin
            req_valid = (c == 3) ? 4'b0100 : 4'b0101;
            #2;
            case (c)
                0:       exp_v = pack(1'b0, 2'd3, 1'b0, 4'b0000, 8'h00);
                1, 2:    exp_v = pack(1'b1, 2'd0, 1'b1, 4'b0001, 8'(c - 1));
                3:       exp_v = pack(1'b1, 2'd0, 1'b0, 4'b0000, 8'h00);
                4:       exp_v = pack(1'b0, 2'd0, 1'b0, 4'b0000, 8'h00);
                default: exp_v = pack(1'b1, 2'd2, 1'b1, 4'b0100, 8'h80 + 8'(c - 5));
            endcase
            obs = pack(busy, grant_id, fifo_we, req_ack, fifo_wdata);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("[TB] FAIL release c%0d: got %h expected %h", c, obs, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_mid_burst_reset();
        do_reset();
        req_valid = 4'b0001;
        for (int c = 0; c < 6; c++) begin
            if (c == 4) begin
                rst       = 1'b0;
                req_valid = 4'b1000;
            end
            #1;
            case (c)
                0:       exp_v = pack(1'b0, 2'd3, 1'b0, 4'b0000, 8'h00);
                1, 2, 3: exp_v = pack(1'b1, 2'd0, 1'b1, 4'b0001, 8'(c - 1));
                4:       exp_v = pack(1'b0, 2'd3, 1'b0, 4'b0000, 8'h00);
                default: exp_v = pack(1'b1, 2'd3, 1'b1, 4'b1000, 8'hC0);
            endcase
            obs = pack(busy, grant_id, fifo_we, req_ack, fifo_wdata);
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("[TB] FAIL rst_burst c%0d: got %h expected %h", c, obs, exp_v);
            end
            if (c == 3) begin
                rst = 1'b1;
                #1;
                exp_v = pack(1'b0, 2'd3, 1'b0, 4'b0000, 8'h00);
                obs = pack(busy, grant_id, fifo_we, req_ack, fifo_wdata);
                n_checks++;
                if (obs !== exp_v) begin
                    n_fail++;
                    $display("[TB] FAIL rst_async: got %h expected %h", obs, exp_v);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        int hit;
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            req_valid = 4'($urandom);
            fifo_full = ($urandom_range(0, 3) == 0);
            #2;
            n_checks++;
            if (fifo_we && fifo_full) begin
                n_fail++;
                $display("[TB] FAIL rand_full c%0d: we=%b full=%b required we=0", c, fifo_we, fifo_full);
            end
            n_checks++;
            if (!$onehot0(req_ack) || (fifo_we !== (|req_ack))) begin
                n_fail++;
                $display("[TB] FAIL rand_ack c%0d: ack=%b we=%b required onehot0 ack matching we", c, req_ack, fifo_we);
            end
            hit = -1;
            for (int i = 0; i < NREQ; i++) if (req_ack[i]) hit = i;
            n_checks++;
            if (hit >= 0) begin
                if (!req_valid[hit] || fifo_wdata !== base[hit] + 8'(seq[hit])) begin
                    n_fail++;
                    $display("[TB] FAIL rand_data c%0d: p%0d valid=%b data=%h required valid=1 data=%h",
                             c, hit, req_valid[hit], fifo_wdata, base[hit] + 8'(seq[hit]));
                end
            end else if (fifo_wdata !== 8'h00) begin
                n_fail++;
                $display("[TB] FAIL rand_idle_data c%0d: got %h expected 00", c, fifo_wdata);
            end
            tick();
        end
        fifo_full = 1'b0;
        req_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            n_checks++;
            if (seq[i] < 100) begin
                n_fail++;
                $display("[TB] FAIL rand_progress p%0d: got %0d words expected >= 100", i, seq[i]);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        fifo_full = 1'b0;
        req_data  = '0;
        test_reset();
        test_single_producer();
        test_round_robin();
        test_full_stall();
        test_release();
        test_mid_burst_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
